// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: keyboard, collision and position inputs plus game-state outputs of game_flow_ctrl.
interface game_flow_ctrl_if #(
    parameter int NUM_PLAYERS = 1,
    parameter int COORD_W     = 11,
    parameter int LIVES_W     = 3,
    parameter int LVL_W       = 3
);
    logic                           startOfFrame;
    logic                           spaceBar;
    logic                           allBallsPopped;
    logic [NUM_PLAYERS-1:0]         fire;
    logic [NUM_PLAYERS-1:0]         rightArrow;
    logic [NUM_PLAYERS-1:0]         leftArrow;
    logic [NUM_PLAYERS-1:0]         col_player_ball;
    logic [NUM_PLAYERS-1:0]         col_rope_ball;
    logic [NUM_PLAYERS*COORD_W-1:0] playerX;
    logic [NUM_PLAYERS*COORD_W-1:0] ropeTopY;
    logic [2:0]                     gameState;
    logic [LVL_W-1:0]               level;
    logic [NUM_PLAYERS*LIVES_W-1:0] lives;
    logic [NUM_PLAYERS-1:0]         playerMoveRight;
    logic [NUM_PLAYERS-1:0]         playerMoveLeft;
    logic [NUM_PLAYERS-1:0]         playerVisible;
    logic                           ballVisible;
    logic [NUM_PLAYERS-1:0]         ropeActive;
    logic [NUM_PLAYERS*COORD_W-1:0] ropeX;
    logic [NUM_PLAYERS-1:0]         presentDrop;
    logic                           levelLoad;

    modport master (
        output startOfFrame, spaceBar, allBallsPopped, fire, rightArrow, leftArrow,
               col_player_ball, col_rope_ball, playerX, ropeTopY,
        input  gameState, level, lives, playerMoveRight, playerMoveLeft, playerVisible,
               ballVisible, ropeActive, ropeX, presentDrop, levelLoad
    );

    modport slave (
        input  startOfFrame, spaceBar, allBallsPopped, fire, rightArrow, leftArrow,
               col_player_ball, col_rope_ball, playerX, ropeTopY,
        output gameState, level, lives, playerMoveRight, playerMoveLeft, playerVisible,
               ballVisible, ropeActive, ropeX, presentDrop, levelLoad
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: Bubble Trouble game flow (welcome/play/clear/over/win), lives, levels, ropes, visibility.
// Define GAME_PAUSE_EN to add the PAUSE state toggled by spaceBar during play.
module game_flow_ctrl #(
    parameter int NUM_PLAYERS   = 1,
    parameter int COORD_W       = 11,
    parameter int LIVES_W       = 3,
    parameter int START_LIVES   = 3,
    parameter int NUM_LEVELS    = 4,
    parameter int INVULN_FRAMES = 60,
    parameter int CLEAR_FRAMES  = 90
) (
    input logic              clk,
    input logic              resetN,
    game_flow_ctrl_if.slave  bus
);
    localparam int LVL_W = $clog2(NUM_LEVELS + 1);
    localparam int INV_W = $clog2(INVULN_FRAMES + 2);
    localparam int CLR_W = $clog2(CLEAR_FRAMES + 1);

    typedef enum logic [2:0] {
        WELCOME     = 3'd0,
        PLAY        = 3'd1,
        GAME_OVER   = 3'd2,
        LEVEL_CLEAR = 3'd3,
        WIN         = 3'd4,
        PAUSE       = 3'd5
    } state_t;

    state_t                         state_q, state_d;
    logic [LVL_W-1:0]               level_q, level_d;
    logic [NUM_PLAYERS*LIVES_W-1:0] lives_q, lives_d;
    logic [NUM_PLAYERS-1:0]         rope_q, rope_d;
    logic [NUM_PLAYERS*COORD_W-1:0] ropex_q, ropex_d;
    logic [NUM_PLAYERS*INV_W-1:0]   inv_q, inv_d;
    logic [CLR_W-1:0]               clear_q, clear_d;
    logic [3:0]                     frame_q, frame_d;
    logic                           load_q, load_d;
    logic                           space_prev_q;
    logic [NUM_PLAYERS-1:0]         fire_prev_q, cpb_prev_q, crb_prev_q;
    logic [NUM_PLAYERS-1:0]         alive;
    logic                           space_rise;
    logic [NUM_PLAYERS-1:0]         fire_rise, cpb_rise, crb_rise;

    assign space_rise = bus.spaceBar & ~space_prev_q;
    assign fire_rise  = bus.fire & ~fire_prev_q;
    assign cpb_rise   = bus.col_player_ball & ~cpb_prev_q;
    assign crb_rise   = bus.col_rope_ball & ~crb_prev_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= WELCOME;
            level_q      <= '0;
            lives_q      <= '0;
            rope_q       <= '0;
            ropex_q      <= '0;
            inv_q        <= '0;
            clear_q      <= '0;
            frame_q      <= '0;
            load_q       <= 1'b0;
            space_prev_q <= 1'b0;
            fire_prev_q  <= '0;
            cpb_prev_q   <= '0;
            crb_prev_q   <= '0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            rope_q       <= rope_d;
            ropex_q      <= ropex_d;
            inv_q        <= inv_d;
            clear_q      <= clear_d;
            frame_q      <= frame_d;
            load_q       <= load_d;
            space_prev_q <= bus.spaceBar;
            fire_prev_q  <= bus.fire;
            cpb_prev_q   <= bus.col_player_ball;
            crb_prev_q   <= bus.col_rope_ball;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        rope_d  = rope_q;
        ropex_d = ropex_q;
        inv_d   = inv_q;
        clear_d = clear_q;
        load_d  = 1'b0;
        frame_d = frame_q + 4'(bus.startOfFrame && state_q != PAUSE);
        case (state_q)
            WELCOME: if (space_rise) begin
                state_d = PLAY;
                level_d = LVL_W'(1);
                load_d  = 1'b1;
                inv_d   = '0;
                for (int p = 0; p < NUM_PLAYERS; p++)
                    lives_d[p*LIVES_W +: LIVES_W] = LIVES_W'(START_LIVES);
            end
            PLAY: begin
                // a fresh hit outranks rope clear/fire for that player in the same clock
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    if (!alive[p]) rope_d[p] = 1'b0;
                    else if (cpb_rise[p] && inv_q[p*INV_W +: INV_W] == '0) begin
                        lives_d[p*LIVES_W +: LIVES_W] = lives_q[p*LIVES_W +: LIVES_W] - LIVES_W'(1);
                        inv_d[p*INV_W +: INV_W]       = INV_W'(INVULN_FRAMES);
                        rope_d[p]                     = 1'b0;
                    end else begin
                        if (bus.startOfFrame && inv_q[p*INV_W +: INV_W] != '0)
                            inv_d[p*INV_W +: INV_W] = inv_q[p*INV_W +: INV_W] - INV_W'(1);
                        if (bus.ropeTopY[p*COORD_W +: COORD_W] == '0 || bus.col_rope_ball[p]) rope_d[p] = 1'b0;
                        else if (fire_rise[p] && !rope_q[p]) begin
                            rope_d[p]                   = 1'b1;
                            ropex_d[p*COORD_W +: COORD_W] = bus.playerX[p*COORD_W +: COORD_W];
                        end
                    end
                end
                if (alive == '0) state_d = GAME_OVER;
                else if (bus.allBallsPopped) begin
                    state_d = (level_q == LVL_W'(NUM_LEVELS)) ? WIN : LEVEL_CLEAR;
                    clear_d = CLR_W'(CLEAR_FRAMES);
                end
`ifdef GAME_PAUSE_EN
                else if (space_rise) state_d = PAUSE;
`endif
            end
`ifdef GAME_PAUSE_EN
            PAUSE: if (space_rise) state_d = PLAY;
`endif
            LEVEL_CLEAR: begin
                clear_d = (bus.startOfFrame && clear_q != '0) ? clear_q - CLR_W'(1) : clear_q;
                if (clear_d == '0) begin
                    state_d = PLAY;
                    level_d = level_q + LVL_W'(1);
                    load_d  = 1'b1;
                    inv_d   = '0;
                end
            end
            GAME_OVER, WIN: if (space_rise) begin
                state_d = WELCOME;
                level_d = '0;
            end
            default: state_d = WELCOME;
        endcase
        if (state_d != PLAY && state_d != PAUSE) rope_d = '0;
    end

    always_comb begin
        alive             = '0;
        bus.playerVisible = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            alive[p]             = |lives_q[p*LIVES_W +: LIVES_W];
            bus.playerVisible[p] = alive[p] && (inv_q[p*INV_W +: INV_W] == '0 || frame_q[3]);
        end
    end

    assign bus.gameState       = state_q;
    assign bus.level           = level_q;
    assign bus.lives           = lives_q;
    assign bus.ropeActive      = rope_q;
    assign bus.ropeX           = ropex_q;
    assign bus.levelLoad       = load_q;
    assign bus.ballVisible     = state_q == PLAY || state_q == PAUSE;
    assign bus.playerMoveRight = (state_q == PLAY) ? bus.rightArrow & alive : '0;
    assign bus.playerMoveLeft  = (state_q == PLAY) ? bus.leftArrow & alive : '0;
    assign bus.presentDrop     = (state_q == PLAY) ? crb_rise & rope_q : '0;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed vector table, multi-cycle sequences and a randomized run
// checked against a behavioural game model, for a two-player build.
module tb_game_flow_ctrl;
    localparam int NP = 2, CW = 11, LW = 3, NLV = 4, INV = 60, CLR = 90, LVW = 3;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    game_flow_ctrl_if #(.NUM_PLAYERS(NP), .COORD_W(CW), .LIVES_W(LW), .LVL_W(LVW)) bus ();

    game_flow_ctrl #(
        .NUM_PLAYERS(NP), .COORD_W(CW), .LIVES_W(LW), .START_LIVES(3),
        .NUM_LEVELS(NLV), .INVULN_FRAMES(INV), .CLEAR_FRAMES(CLR)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus)
    );

    int passed = 0, total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        tick();
    endtask

    task automatic hit(input int p);
        bus.col_player_ball[p] = 1'b1;
        tick();
        bus.col_player_ball[p] = 1'b0;
        tick();
        repeat (INV + 1) frame();
    endtask

    // Behavioural model: game rules over plain ints (0 welcome,1 play,2 over,3 clear,4 win,5 pause)
    int m_state, m_level, m_clear, m_frames;
    int m_lives[NP], m_inv[NP], m_ropex[NP];
    bit m_rope[NP];
    bit m_load, p_space;
    bit [NP-1:0] p_fire, p_cpb, p_crb;

    function automatic int fld(input logic [NP*CW-1:0] v, input int p);
        return int'(v[p*CW +: CW]);
    endfunction

    task automatic model_step();
        bit sp = bus.spaceBar && !p_space;
        bit any_alive = 1'b0;
        int nxt = m_state;
        m_load = 1'b0;
        for (int p = 0; p < NP; p++) if (m_lives[p] > 0) any_alive = 1'b1;
        if (bus.startOfFrame && m_state != 5) m_frames++;
        case (m_state)
            0: if (sp) begin
                nxt = 1; m_level = 1; m_load = 1'b1;
                for (int p = 0; p < NP; p++) begin m_lives[p] = 3; m_inv[p] = 0; end
            end
            1: begin
                for (int p = 0; p < NP; p++) begin
                    if (m_lives[p] == 0) m_rope[p] = 1'b0;
                    else if (bus.col_player_ball[p] && !p_cpb[p] && m_inv[p] == 0) begin
                        m_lives[p]--; m_inv[p] = INV; m_rope[p] = 1'b0;
                    end else begin
                        if (bus.startOfFrame && m_inv[p] > 0) m_inv[p]--;
                        if (fld(bus.ropeTopY, p) == 0 || bus.col_rope_ball[p]) m_rope[p] = 1'b0;
                        else if (bus.fire[p] && !p_fire[p] && !m_rope[p]) begin
                            m_rope[p] = 1'b1; m_ropex[p] = fld(bus.playerX, p);
                        end
                    end
                end
                if (!any_alive) nxt = 2;
                else if (bus.allBallsPopped) begin
                    nxt = (m_level == NLV) ? 4 : 3;
                    m_clear = CLR;
                end
`ifdef GAME_PAUSE_EN
                else if (sp) nxt = 5;
`endif
            end
            3: begin
                if (bus.startOfFrame && m_clear > 0) m_clear--;
                if (m_clear == 0) begin
                    nxt = 1; m_level++; m_load = 1'b1;
                    for (int p = 0; p < NP; p++) m_inv[p] = 0;
                end
            end
            2, 4: if (sp) begin nxt = 0; m_level = 0; end
            5: if (sp) nxt = 1;
            default: nxt = 0;
        endcase
        if (nxt != 1 && nxt != 5) for (int p = 0; p < NP; p++) m_rope[p] = 1'b0;
        m_state = nxt;
        p_space = bus.spaceBar;
        p_fire  = bus.fire;
        p_cpb   = bus.col_player_ball;
        p_crb   = bus.col_rope_ball;
    endtask

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_state = 0; m_level = 0; m_clear = 0; m_frames = 0; m_load = 1'b0;
            p_space = 1'b0; p_fire = '0; p_cpb = '0; p_crb = '0;
            for (int p = 0; p < NP; p++) begin
                m_lives[p] = 0; m_inv[p] = 0; m_rope[p] = 1'b0; m_ropex[p] = 0;
            end
        end else model_step();
    end

    task automatic cmp_model();
        logic [NP*LW-1:0] el;
        logic [NP*CW-1:0] ex;
        logic [NP-1:0] er, ev, emr, eml, epd;
        for (int p = 0; p < NP; p++) begin
            el[p*LW +: LW] = LW'(m_lives[p]);
            ex[p*CW +: CW] = CW'(m_ropex[p]);
            er[p]  = m_rope[p];
            ev[p]  = m_lives[p] > 0 && (m_inv[p] == 0 || (m_frames / 8) % 2 == 1);
            emr[p] = m_state == 1 && m_lives[p] > 0 && bus.rightArrow[p];
            eml[p] = m_state == 1 && m_lives[p] > 0 && bus.leftArrow[p];
            epd[p] = m_state == 1 && m_rope[p] && bus.col_rope_ball[p] && !p_crb[p];
        end
        check("rnd_state", 64'(bus.gameState), 64'(m_state));
        check("rnd_level", 64'(bus.level), 64'(m_level));
        check("rnd_lives", 64'(bus.lives), 64'(el));
        check("rnd_rope", 64'(bus.ropeActive), 64'(er));
        check("rnd_ropex", 64'(bus.ropeX), 64'(ex));
        check("rnd_visible", 64'(bus.playerVisible), 64'(ev));
        check("rnd_ballvis", 64'(bus.ballVisible), 64'(m_state == 1 || m_state == 5));
        check("rnd_moves", 64'({bus.playerMoveRight, bus.playerMoveLeft}), 64'({emr, eml}));
        check("rnd_drop", 64'(bus.presentDrop), 64'(epd));
        check("rnd_load", 64'(bus.levelLoad), 64'(m_load));
    endtask

    typedef struct {
        logic        space, fire0;
        logic [10:0] px0, rtop0;
        logic [2:0]  st, lvl;
        logic [5:0]  lives;
        logic        rope0;
        logic [10:0] rx0;
        logic        load;
    } vec_t;

    function automatic vec_t mk(input logic sp, f, input logic [10:0] px, rt,
                                input logic [2:0] st, lv, input logic [5:0] li,
                                input logic r, input logic [10:0] rx, input logic ld);
        vec_t v;
        v.space = sp; v.fire0 = f; v.px0 = px; v.rtop0 = rt; v.st = st; v.lvl = lv;
        v.lives = li; v.rope0 = r; v.rx0 = rx; v.load = ld;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        tbl[0]  = mk(0, 0,   0, 500, 0, 0,  0, 0,   0, 0);
        tbl[1]  = mk(1, 0,   0, 500, 1, 1, 27, 0,   0, 1);
        tbl[2]  = mk(1, 0,   0, 500, 1, 1, 27, 0,   0, 0);
        tbl[3]  = mk(0, 1, 200, 500, 1, 1, 27, 1, 200, 0);
        tbl[4]  = mk(0, 1, 300, 500, 1, 1, 27, 1, 200, 0);
        tbl[5]  = mk(0, 0, 300, 500, 1, 1, 27, 1, 200, 0);
        tbl[6]  = mk(0, 0, 300,   0, 1, 1, 27, 0, 200, 0);
        tbl[7]  = mk(0, 1, 300, 500, 1, 1, 27, 1, 300, 0);
        tbl[8]  = mk(0, 1, 300,   0, 1, 1, 27, 0, 300, 0);
        tbl[9]  = mk(0, 1, 300, 500, 1, 1, 27, 0, 300, 0);
        tbl[10] = mk(0, 0, 300, 500, 1, 1, 27, 0, 300, 0);
        tbl[11] = mk(0, 1,   7, 500, 1, 1, 27, 1,   7, 0);

        bus.startOfFrame = 0; bus.spaceBar = 0; bus.allBallsPopped = 0;
        bus.fire = '0; bus.rightArrow = '0; bus.leftArrow = '0;
        bus.col_player_ball = '0; bus.col_rope_ball = '0;
        bus.playerX = '0; bus.ropeTopY = {NP{11'd500}};
        tick();
        tick();
        check("rst_state", 64'(bus.gameState), 0);
        check("rst_level", 64'(bus.level), 0);
        check("rst_lives", 64'(bus.lives), 0);
        check("rst_rope", 64'({bus.ropeActive, bus.ropeX}), 0);
        check("rst_pulses", 64'({bus.levelLoad, bus.presentDrop, bus.ballVisible}), 0);
        resetN = 1'b1;

        foreach (tbl[i]) begin
            bus.spaceBar = tbl[i].space;
            bus.fire[0] = tbl[i].fire0;
            bus.playerX[CW-1:0] = tbl[i].px0;
            bus.ropeTopY[CW-1:0] = tbl[i].rtop0;
            tick();
            check($sformatf("vec%0d_state", i), 64'(bus.gameState), 64'(tbl[i].st));
            check($sformatf("vec%0d_level", i), 64'(bus.level), 64'(tbl[i].lvl));
            check($sformatf("vec%0d_lives", i), 64'(bus.lives), 64'(tbl[i].lives));
            check($sformatf("vec%0d_rope", i), 64'(bus.ropeActive[0]), 64'(tbl[i].rope0));
            check($sformatf("vec%0d_ropex", i), 64'(bus.ropeX[CW-1:0]), 64'(tbl[i].rx0));
            check($sformatf("vec%0d_load", i), 64'(bus.levelLoad), 64'(tbl[i].load));
        end

        // rope hit by ball: one presentDrop pulse, rope cleared
        bus.col_rope_ball = 2'b01;
        #2;
        check("drop_pulse", 64'(bus.presentDrop), 1);
        tick();
        check("drop_rope_clr", 64'(bus.ropeActive), 0);
        #2;
        check("drop_held", 64'(bus.presentDrop), 0);
        bus.col_rope_ball = '0;
        bus.fire = '0;
        tick();

        // fire held for 100 clocks after the rope dies never refires
        bus.fire = 2'b01; bus.playerX[CW-1:0] = 11'd200;
        tick();
        check("hold_fire_set", 64'({bus.ropeActive[0], bus.ropeX[CW-1:0]}), 64'({1'b1, 11'd200}));
        bus.ropeTopY[CW-1:0] = 11'd0;
        tick();
        bus.ropeTopY[CW-1:0] = 11'd500;
        repeat (100) tick();
        check("hold_fire_norefire", 64'(bus.ropeActive), 0);
        bus.fire = '0;

        // held ball contact costs one life only
        bus.col_player_ball = 2'b01;
        tick();
        check("hit_once", 64'(bus.lives), 26);
        repeat (200) frame();
        check("hit_held", 64'(bus.lives), 26);
        check("hit_visible_after", 64'(bus.playerVisible), 2'b11);
        bus.col_player_ball = '0;
        tick();
        bus.col_player_ball = 2'b01;
        tick();
        check("hit_retouch", 64'(bus.lives), 25);
        bus.col_player_ball = '0;
        repeat (INV + 1) frame();

        // player 0 dies, player 1 keeps playing
        hit(0);
        check("p0_dead_lives", 64'(bus.lives), 24);
        check("p0_dead_state", 64'(bus.gameState), 1);
        check("p0_dead_vis", 64'(bus.playerVisible[0]), 0);
        bus.rightArrow = 2'b11;
        #2;
        check("p0_dead_move", 64'(bus.playerMoveRight), 2'b10);
        bus.rightArrow = '0;
        bus.fire = 2'b01;
        tick();
        check("p0_dead_fire", 64'(bus.ropeActive), 0);
        bus.fire = '0;
        repeat (3) hit(1);
        check("all_dead_state", 64'(bus.gameState), 2);
        check("all_dead_ball", 64'(bus.ballVisible), 0);

        bus.spaceBar = 1; tick();
        check("over_to_welcome", 64'({bus.gameState, bus.level}), 0);
        bus.spaceBar = 0; tick();
        bus.spaceBar = 1; tick();
        check("restart", 64'({bus.gameState, bus.level, bus.lives, bus.levelLoad}),
              64'({3'd1, 3'd1, 6'd27, 1'b1}));
        bus.spaceBar = 0; tick();
        check("restart_load_clr", 64'(bus.levelLoad), 0);

        // level clear sequence
        bus.fire = 2'b01; bus.playerX[CW-1:0] = 11'd123;
        tick();
        check("clear_rope_pre", 64'(bus.ropeActive), 1);
        bus.fire = '0; bus.allBallsPopped = 1;
        tick();
        bus.allBallsPopped = 0;
        check("clear_enter", 64'({bus.gameState, bus.ropeActive}), 64'({3'd3, 2'b00}));
        repeat (CLR - 1) frame();
        check("clear_wait", 64'({bus.gameState, bus.level}), 64'({3'd3, 3'd1}));
        bus.startOfFrame = 1; tick(); bus.startOfFrame = 0;
        check("clear_done", 64'({bus.gameState, bus.level, bus.levelLoad, bus.lives}),
              64'({3'd1, 3'd2, 1'b1, 6'd27}));
        tick();
        check("clear_load_clr", 64'(bus.levelLoad), 0);
        for (int l = 2; l < NLV; l++) begin
            bus.allBallsPopped = 1; tick(); bus.allBallsPopped = 0;
            repeat (CLR) frame();
            check($sformatf("level%0d_next", l), 64'({bus.gameState, bus.level}), 64'({3'd1, 3'(l + 1)}));
        end
        bus.allBallsPopped = 1; tick(); bus.allBallsPopped = 0;
        check("win", 64'({bus.gameState, bus.ballVisible}), 64'({3'd4, 1'b0}));
        bus.spaceBar = 1; tick(); bus.spaceBar = 0; tick();
        check("win_to_welcome", 64'({bus.gameState, bus.level}), 0);
        bus.spaceBar = 1; tick(); bus.spaceBar = 0; tick();

`ifdef GAME_PAUSE_EN
        bus.spaceBar = 1; tick(); bus.spaceBar = 0;
        check("pause_enter", 64'({bus.gameState, bus.ballVisible}), 64'({3'd5, 1'b1}));
        bus.col_player_ball = 2'b11;
        repeat (50) tick();
        check("pause_lives", 64'(bus.lives), 27);
        bus.spaceBar = 1; tick(); bus.spaceBar = 0;
        check("pause_exit", 64'(bus.gameState), 1);
        bus.col_player_ball = '0; tick();
`else
        bus.spaceBar = 1; tick(); bus.spaceBar = 0;
        check("space_in_play", 64'(bus.gameState), 1);
        tick();
`endif

        // asynchronous reset in the middle of a level clear
        bus.allBallsPopped = 1; tick(); bus.allBallsPopped = 0;
        repeat (5) frame();
        #2 resetN = 1'b0;
        #1;
        check("async_rst", 64'({bus.gameState, bus.level, bus.lives, bus.levelLoad}), 0);
        tick();
        resetN = 1'b1;
        tick();

        for (int c = 0; c < 3000; c++) begin
            bus.spaceBar = ($urandom_range(0, 29) == 0);
            bus.startOfFrame = ($urandom_range(0, 3) == 0);
            bus.allBallsPopped = ($urandom_range(0, 199) == 0);
            bus.fire = NP'($urandom);
            bus.rightArrow = NP'($urandom);
            bus.leftArrow = NP'($urandom);
            for (int p = 0; p < NP; p++) begin
                bus.col_player_ball[p] = ($urandom_range(0, 15) == 0);
                bus.col_rope_ball[p] = ($urandom_range(0, 7) == 0);
                bus.playerX[p*CW +: CW] = CW'($urandom);
                bus.ropeTopY[p*CW +: CW] = ($urandom_range(0, 9) == 0) ? '0 : CW'($urandom_range(1, 2047));
            end
            #2;
            cmp_model();
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
